// File: rtl/cam_dma_pkg.sv
// Shared definitions for the camera DMA masters: FSM encoding, burst sizing
// and the FIFO fill-count width rule.
package cam_dma_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } bwm_state_e;

   // One extra bit so a completely full FIFO has a distinct count.
   function automatic int unsigned fifo_cnt_w(input int unsigned depth_log2);
      return depth_log2 + 1;
   endfunction

   // Beats for the next burst. Unless the target is a fixed location, a burst
   // starting mid-window is cut short so the following one lands aligned.
   function automatic logic [31:0] burst_size(input logic [31:0] address,
                                              input logic [31:0] length,
                                              input logic        fixed,
                                              input logic [31:0] max_burst,
                                              input int unsigned be_log2);
      logic [31:0] wb, words, lim;
      wb    = (address >> be_log2) & (max_burst - 32'd1);
      words = length >> be_log2;
      lim   = (fixed || wb == 32'd0) ? max_burst : max_burst - wb;
      return (words < lim) ? words : lim;
   endfunction

endpackage

// File: rtl/bwm_sync_fifo.sv
// Single-clock show-ahead FIFO: q is the current head, pushes while full and
// pops while empty are ignored.
module bwm_sync_fifo #(
   parameter int WIDTH      = 32,
   parameter int DEPTH      = 32,
   parameter int DEPTH_LOG2 = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wrreq,
   input  logic [WIDTH-1:0]      data,
   input  logic                  rdreq,
   output logic [WIDTH-1:0]      q,
   output logic                  empty,
   output logic                  full,
   output logic [DEPTH_LOG2:0]   usedw
);

   logic [WIDTH-1:0]      mem_q [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [DEPTH_LOG2:0]   cnt_q, cnt_d;
   logic                  wr_en, rd_en;

   assign full  = (cnt_q == (DEPTH_LOG2+1)'(DEPTH));
   assign empty = (cnt_q == '0);
   assign usedw = cnt_q;
   assign q     = mem_q[rd_ptr_q];

   // Full is judged on the registered count, so a same-cycle pop never
   // rescues a push into a full FIFO.
   assign wr_en = wrreq & ~full;
   assign rd_en = rdreq & ~empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q + {{(DEPTH_LOG2-1){1'b0}}, wr_en};
      rd_ptr_d = rd_ptr_q + {{(DEPTH_LOG2-1){1'b0}}, rd_en};
      cnt_d    = cnt_q + {{DEPTH_LOG2{1'b0}}, wr_en} - {{DEPTH_LOG2{1'b0}}, rd_en};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q] <= data;
   end

endmodule

// File: rtl/cam_burst_write_master.sv
// Avalon-MM bursting write master draining a local FIFO to memory.
// Define CAM_BURST_WRITE_MASTER_OVERFLOW_EN to build the sticky overflow flag.
module cam_burst_write_master
   import cam_dma_pkg::*;
#(
   parameter int DATAWIDTH       = 32,
   parameter int MAXBURSTCOUNT   = 4,
   parameter int BURSTCOUNTWIDTH = 3,
   parameter int BYTEENABLEWIDTH = 4,
   parameter int ADDRESSWIDTH    = 32,
   parameter int FIFODEPTH       = 32,
   parameter int FIFODEPTH_LOG2  = 5
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       control_fixed_location,
   input  logic [ADDRESSWIDTH-1:0]    control_write_base,
   input  logic [ADDRESSWIDTH-1:0]    control_write_length,
   input  logic                       control_go,
   output logic                       control_done,
   output logic                       control_overflow,
   input  logic                       user_write_buffer,
   input  logic [DATAWIDTH-1:0]       user_buffer_data,
   output logic                       user_buffer_full,
   output logic [ADDRESSWIDTH-1:0]    master_address,
   output logic                       master_write,
   output logic [BYTEENABLEWIDTH-1:0] master_byteenable,
   output logic [DATAWIDTH-1:0]       master_writedata,
   output logic [BURSTCOUNTWIDTH-1:0] master_burstcount,
   input  logic                       master_waitrequest
);

   localparam int CNTW    = fifo_cnt_w(FIFODEPTH_LOG2);
   localparam int BE_LOG2 = $clog2(BYTEENABLEWIDTH);

   bwm_state_e                 state_q, state_d;
   logic [ADDRESSWIDTH-1:0]    address_q, address_d;
   logic [ADDRESSWIDTH-1:0]    length_q, length_d;
   logic                       fixed_q, fixed_d;
   logic [BURSTCOUNTWIDTH-1:0] burst_reg_q, burst_reg_d;
   logic [BURSTCOUNTWIDTH-1:0] beats_left_q, beats_left_d;

   logic [CNTW-1:0]            fifo_used;
   logic                       fifo_empty, fifo_full, fifo_pop;
   logic [31:0]                next_burst;
   logic                       burst_ready;

   bwm_sync_fifo #(
      .WIDTH      (DATAWIDTH),
      .DEPTH      (FIFODEPTH),
      .DEPTH_LOG2 (FIFODEPTH_LOG2)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .wrreq (user_write_buffer),
      .data  (user_buffer_data),
      .rdreq (fifo_pop),
      .q     (master_writedata),
      .empty (fifo_empty),
      .full  (fifo_full),
      .usedw (fifo_used)
   );

   assign next_burst  = burst_size(32'(address_q), 32'(length_q), fixed_q,
                                   32'(MAXBURSTCOUNT), BE_LOG2);
   // Only start once the whole burst is buffered so the bus never idles mid-burst.
   assign burst_ready = !fifo_empty && (32'(fifo_used) >= next_burst);

   assign user_buffer_full  = fifo_full;
   assign master_address    = address_q;
   assign master_burstcount = burst_reg_q;
   assign master_byteenable = '1;
   assign control_done      = (length_q == '0) && (state_q == IDLE);

   always_comb begin
      state_d      = state_q;
      address_d    = address_q;
      length_d     = length_q;
      fixed_d      = fixed_q;
      burst_reg_d  = burst_reg_q;
      beats_left_d = beats_left_q;
      fifo_pop     = 1'b0;
      master_write = (state_q == BURST);
      case (state_q)
         IDLE: begin
            if (control_go) begin
               address_d = control_write_base;
               length_d  = control_write_length & ~ADDRESSWIDTH'(BYTEENABLEWIDTH - 1);
               fixed_d   = control_fixed_location;
            end else if (length_q != '0 && burst_ready) begin
               state_d      = BURST;
               burst_reg_d  = BURSTCOUNTWIDTH'(next_burst);
               beats_left_d = BURSTCOUNTWIDTH'(next_burst);
            end
         end
         BURST: begin
            if (!master_waitrequest) begin
               fifo_pop     = 1'b1;
               beats_left_d = beats_left_q - BURSTCOUNTWIDTH'(1);
               length_d     = length_q - ADDRESSWIDTH'(BYTEENABLEWIDTH);
               if (beats_left_q == BURSTCOUNTWIDTH'(1)) begin
                  if (!fixed_q)
                     address_d = address_q + (ADDRESSWIDTH'(burst_reg_q) << BE_LOG2);
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         address_q    <= '0;
         length_q     <= '0;
         fixed_q      <= 1'b0;
         burst_reg_q  <= '0;
         beats_left_q <= '0;
      end else begin
         state_q      <= state_d;
         address_q    <= address_d;
         length_q     <= length_d;
         fixed_q      <= fixed_d;
         burst_reg_q  <= burst_reg_d;
         beats_left_q <= beats_left_d;
      end
   end

`ifdef CAM_BURST_WRITE_MASTER_OVERFLOW_EN
   logic overflow_q, overflow_d;

   // A drop in the same cycle as go still sets the flag.
   always_comb begin
      overflow_d = overflow_q;
      if (control_go && state_q == IDLE) overflow_d = 1'b0;
      if (user_write_buffer && fifo_full) overflow_d = 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) overflow_q <= 1'b0;
      else       overflow_q <= overflow_d;
   end

   assign control_overflow = overflow_q;
`else
   assign control_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_cam_burst_write_master.sv
// Randomised scoreboard bench for cam_burst_write_master: expected bursts are
// queued at each go, a negedge monitor checks every beat against a FIFO model.
module tb_cam_burst_write_master;

   localparam int DEPTH = 32;

   typedef struct {
      int unsigned addr;
      int unsigned cnt;
   } burst_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        control_fixed_location = 1'b0;
   logic [31:0] control_write_base = '0;
   logic [31:0] control_write_length = '0;
   logic        control_go = 1'b0;
   logic        control_done, control_overflow;
   logic        user_write_buffer = 1'b0;
   logic [31:0] user_buffer_data = '0;
   logic        user_buffer_full;
   logic [31:0] master_address;
   logic        master_write;
   logic [3:0]  master_byteenable;
   logic [31:0] master_writedata;
   logic [2:0]  master_burstcount;
   logic        master_waitrequest = 1'b0;

   cam_burst_write_master dut (
      .clk                    (clk),
      .reset                  (reset),
      .control_fixed_location (control_fixed_location),
      .control_write_base     (control_write_base),
      .control_write_length   (control_write_length),
      .control_go             (control_go),
      .control_done           (control_done),
      .control_overflow       (control_overflow),
      .user_write_buffer      (user_write_buffer),
      .user_buffer_data       (user_buffer_data),
      .user_buffer_full       (user_buffer_full),
      .master_address         (master_address),
      .master_write           (master_write),
      .master_byteenable      (master_byteenable),
      .master_writedata       (master_writedata),
      .master_burstcount      (master_burstcount),
      .master_waitrequest     (master_waitrequest)
   );

   always #5 clk = ~clk;

   // scoreboard / model state
   burst_t      exp_bursts[$];
   logic [31:0] mq[$];
   burst_t      cur;
   int          beats_rem = 0;
   bit          exp_ovf = 1'b0, exp_done = 1'b1;
   bit          idle_on = 1'b0, idle_ok = 1'b0;
   int          idle_cnt = 0;
   bit          stalled = 1'b0;
   logic [31:0] st_addr, st_data;
   logic [2:0]  st_bc;
   bit          rst_checked = 1'b0;
   int          vecs = 0, errs = 0;
   int          tmo = 0;
   bit          end_req = 1'b0;

   // stimulus drivers
   int          push_req = 0, push_done = 0, push_period = 1, ph = 0;
   bit          push_rand = 1'b0;
   bit          wr_rand = 1'b0, wr_force = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Expected burst list from the transfer rules, using plain word arithmetic.
   function automatic void make_bursts(input int unsigned base, input int unsigned len, input bit fx);
      int unsigned a = base;
      int unsigned w = len / 4;
      while (w > 0) begin
         int unsigned lim = fx ? 4 : 4 - ((a / 4) % 4);
         int unsigned c = (w < lim) ? w : lim;
         exp_bursts.push_back('{a, c});
         if (!fx) a += 4 * c;
         w -= c;
      end
   endfunction

   always @(posedge clk) begin
      #1;
      user_write_buffer = 1'b0;
      if (!reset && push_done != push_req) begin
         if (push_rand ? ($urandom_range(0, 2) != 0) : (ph == 0)) begin
            user_write_buffer = 1'b1;
            user_buffer_data  = $urandom;
            push_done++;
         end
      end
      ph = (ph + 1 >= push_period) ? 0 : ph + 1;
   end

   always @(posedge clk) begin
      #1;
      master_waitrequest = wr_rand ? ($urandom_range(0, 3) == 0) : wr_force;
   end

   // monitor: compare outputs, then advance the model by what the next edge does
   always @(negedge clk) begin
      if (!reset) begin
         bit accept, full_before;
         if (!rst_checked) begin
            rst_checked = 1'b1;
            chk("rst_write", 64'(master_write), 64'(0));
            chk("rst_burstcount", 64'(master_burstcount), 64'(0));
            chk("rst_address", 64'(master_address), 64'(0));
            chk("rst_byteenable", 64'(master_byteenable), 64'hF);
         end
         chk("full", 64'(user_buffer_full), 64'(mq.size() == DEPTH));
         chk("overflow", 64'(control_overflow), 64'(exp_ovf));
         chk("done", 64'(control_done), 64'(exp_done));

         if (idle_on) begin
            if (master_write) begin
               if (idle_ok) chk("idle_cycles", 64'(idle_cnt), 64'(1));
               idle_on = 1'b0;
            end else idle_cnt++;
         end
         if (beats_rem != 0) chk("burst_write", 64'(master_write), 64'(1));

         if (master_write && master_waitrequest) begin
            if (stalled) begin
               chk("stall_address", 64'(master_address), 64'(st_addr));
               chk("stall_burstcount", 64'(master_burstcount), 64'(st_bc));
               chk("stall_writedata", 64'(master_writedata), 64'(st_data));
            end
            st_addr = master_address; st_bc = master_burstcount; st_data = master_writedata;
            stalled = 1'b1;
         end else stalled = 1'b0;

         accept = master_write && !master_waitrequest;
         if (accept) begin
            if (beats_rem == 0) begin
               if (exp_bursts.size() == 0) begin
                  chk("unexpected_burst", 64'(exp_bursts.size()), 64'(1));
                  cur = '{master_address, (master_burstcount == 0) ? 1 : master_burstcount};
               end else begin
                  cur = exp_bursts.pop_front();
                  chk("burst_address", 64'(master_address), 64'(cur.addr));
                  chk("burstcount", 64'(master_burstcount), 64'(cur.cnt));
                  chk("burst_buffered", 64'(mq.size() >= cur.cnt), 64'(1));
               end
               beats_rem = cur.cnt;
            end else begin
               chk("hold_address", 64'(master_address), 64'(cur.addr));
               chk("hold_burstcount", 64'(master_burstcount), 64'(cur.cnt));
            end
            if (mq.size() == 0) chk("fifo_nonempty", 64'(mq.size() != 0), 64'(1));
            else chk("writedata", 64'(master_writedata), 64'(mq[0]));
            beats_rem--;
         end

         full_before = (mq.size() == DEPTH);
         if (accept && mq.size() != 0) void'(mq.pop_front());
         if (control_go) begin
            exp_ovf  = 1'b0;
            exp_done = (exp_bursts.size() == 0);
         end
         if (user_write_buffer) begin
            if (!full_before) mq.push_back(user_buffer_data);
`ifdef CAM_BURST_WRITE_MASTER_OVERFLOW_EN
            else exp_ovf = 1'b1;
`endif
         end
         if ((control_go || (accept && beats_rem == 0)) && exp_bursts.size() != 0) begin
            idle_on  = 1'b1;
            idle_cnt = 0;
            idle_ok  = (mq.size() >= exp_bursts[0].cnt);
         end else if (accept && beats_rem == 0) exp_done = 1'b1;

         if (end_req) begin
            chk("timeouts", 64'(tmo), 64'(0));
            chk("leftover_words", 64'(mq.size()), 64'(0));
            $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
            $finish;
         end
      end
   end

   task automatic push_n(input int n, input int period, input bit rnd);
      push_period = period;
      push_rand   = rnd;
      push_req    = push_req + n;
   endtask

   task automatic do_go(input int unsigned base, input int unsigned len, input bit fx);
      @(posedge clk); #1;
      control_write_base     = base;
      control_write_length   = len;
      control_fixed_location = fx;
      make_bursts(base, len, fx);
      control_go = 1'b1;
      @(posedge clk); #1;
      control_go = 1'b0;
   endtask

   task automatic wait_pushes();
      int t = 0;
      while (push_done != push_req && t < 2000) begin @(negedge clk); t++; end
      if (t >= 2000) tmo++;
      @(negedge clk);
   endtask

   task automatic wait_idle();
      int t = 0;
      while (!(push_done == push_req && exp_bursts.size() == 0 && beats_rem == 0 && control_done)
             && t < 4000) begin
         @(negedge clk); t++;
      end
      if (t >= 4000) tmo++;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      repeat (2) @(posedge clk);

      // aligned, prefilled
      push_n(8, 1, 1'b0); wait_pushes();
      do_go(32'h100, 32, 1'b0); wait_idle();

      // unaligned start realigns on the second burst
      push_n(6, 1, 1'b0); wait_pushes();
      do_go(32'h104, 24, 1'b0); wait_idle();

      // slow producer: burst must wait for a full burst of data
      push_n(4, 3, 1'b0);
      do_go(32'h0, 16, 1'b0); wait_idle();

      // stall on beat 2 for five cycles
      push_n(4, 1, 1'b0); wait_pushes();
      do_go(32'h200, 16, 1'b0);
      begin
         int t = 0;
         while (!master_write && t < 100) begin @(negedge clk); t++; end
         if (t >= 100) tmo++;
      end
      wr_force = 1'b1;
      repeat (5) @(posedge clk);
      wr_force = 1'b0;
      wait_idle();

      // overfill an idle FIFO, then drain it
      push_n(33, 1, 1'b0); wait_pushes();
      repeat (3) @(negedge clk);
      do_go(32'h300, 128, 1'b0); wait_idle();

      // fixed location
      push_n(5, 1, 1'b0); wait_pushes();
      do_go(32'h40, 20, 1'b1); wait_idle();

      // randomised transfers with random stalls
      wr_rand = 1'b1;
      for (int i = 0; i < 10; i++) begin
         int unsigned base = $urandom_range(0, 255) * 4;
         int unsigned len  = $urandom_range(0, 128);
         bit          fx   = ($urandom_range(0, 3) == 0);
         bit          pre  = $urandom_range(0, 1);
         push_n(int'(len / 4), 1, 1'b1);
         if (pre) wait_pushes();
         do_go(base, len, fx);
         wait_idle();
      end
      wr_rand = 1'b0;
      repeat (3) @(negedge clk);
      end_req = 1'b1;
   end

endmodule
